// File: rtl/acq_readout_seq.sv
// Acquisition sequencer for the ADC->FIFO path: arm pulse, write window, then
// toggle-handshaked single-word FIFO drain under control of the PS command word.
module acq_readout_seq #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TO_W    = 24,
  parameter int unsigned ARM_CYC = 4,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic              sys_clk,
  input  logic              _RESET_in,
  input  logic [3:0]        CMD_in,
  input  logic [CNT_W-1:0]  acq_len_in,
  input  logic [TO_W-1:0]   timeout_in,
  input  logic [CNT_W-1:0]  DATAcnt_in,
  input  logic              full_in,
  input  logic              empty_in,
  input  logic [DATA_W-1:0] DATA_in,
  output logic              DATAread_out,
  output logic              _RESET_out,
  output logic              SLEAP_out,
  output logic [DATA_W-1:0] DATA_out,
  output logic              ack_out,
  output logic [2:0]        state_out,
  output logic [CNT_W-1:0]  words_out,
  output logic              ovf_out,
  output logic              udr_out
);

  localparam int unsigned ArmW = $clog2(ARM_CYC + 1);
  localparam int unsigned LatW = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArm   = 3'd1,
    StRun   = 3'd2,
    StDrain = 3'd3,
    StRead  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cmd_q;
  logic [ArmW-1:0]     arm_cnt_q, arm_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [LatW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                ack_q, ack_d;
  logic [CNT_W-1:0]    words_q, words_d;
  logic                ovf_q, ovf_d;
  logic                udr_q, udr_d;
  logic                def_start_q, def_start_d;
  logic                strobe;
  logic                arm_entry;

  logic start_e, stop_e, abort_e, pending, len_hit, to_hit;

  assign start_e = CMD_in[0] & ~cmd_q[0];
  assign stop_e  = CMD_in[1] & ~cmd_q[1];
  assign abort_e = CMD_in[3] & ~cmd_q[3];
  assign pending = cmd_q[2] ^ ack_q;
  assign len_hit = (acq_len_in != '0) && (DATAcnt_in >= acq_len_in);
  assign to_hit  = (timeout_in != '0) && (to_cnt_q == timeout_in - TO_W'(1));

  always_comb begin
    state_d     = state_q;
    arm_cnt_d   = arm_cnt_q;
    to_cnt_d    = to_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    data_d      = data_q;
    ack_d       = ack_q;
    words_d     = words_q;
    ovf_d       = ovf_q;
    udr_d       = udr_q;
    def_start_d = def_start_q;
    strobe      = 1'b0;
    arm_entry   = 1'b0;

    if (abort_e) begin
      // Re-align the handshake so no request survives the abort.
      state_d     = StIdle;
      ack_d       = cmd_q[2];
      arm_cnt_d   = '0;
      rd_cnt_d    = '0;
      def_start_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_e && !stop_e) begin
            state_d   = StArm;
            arm_entry = 1'b1;
          end
        end
        StArm: begin
          if (stop_e) begin
            state_d = StIdle;
          end else if (arm_cnt_q == ArmW'(ARM_CYC - 1)) begin
            state_d = StRun;
          end else begin
            arm_cnt_d = arm_cnt_q + ArmW'(1);
          end
        end
        StRun: begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (full_in) ovf_d = 1'b1;
          if (stop_e || len_hit || to_hit || full_in) state_d = StDrain;
        end
        StDrain: begin
          // A start deferred from READ is consumed here; a stop edge cancels it.
          def_start_d = 1'b0;
          if ((start_e || def_start_q) && !stop_e) begin
            state_d   = StArm;
            arm_entry = 1'b1;
          end else if (pending) begin
            if (!empty_in) begin
              strobe   = 1'b1;
              rd_cnt_d = '0;
              state_d  = StRead;
            end else begin
              ack_d = ~ack_q;
              udr_d = 1'b1;
            end
          end
        end
        StRead: begin
          if (stop_e) def_start_d = 1'b0;
          else if (start_e) def_start_d = 1'b1;
          if (rd_cnt_q == LatW'(RD_LAT - 1)) begin
            data_d  = DATA_in;
            ack_d   = ~ack_q;
            state_d = StDrain;
            if (words_q != '1) words_d = words_q + CNT_W'(1);
          end else begin
            rd_cnt_d = rd_cnt_q + LatW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (arm_entry) begin
      arm_cnt_d = '0;
      to_cnt_d  = '0;
      words_d   = '0;
      ovf_d     = 1'b0;
      udr_d     = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge _RESET_in) begin
    if (!_RESET_in) begin
      state_q     <= StIdle;
      cmd_q       <= '0;
      arm_cnt_q   <= '0;
      to_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      data_q      <= '0;
      ack_q       <= 1'b0;
      words_q     <= '0;
      ovf_q       <= 1'b0;
      udr_q       <= 1'b0;
      def_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= CMD_in;
      arm_cnt_q   <= arm_cnt_d;
      to_cnt_q    <= to_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      data_q      <= data_d;
      ack_q       <= ack_d;
      words_q     <= words_d;
      ovf_q       <= ovf_d;
      udr_q       <= udr_d;
      def_start_q <= def_start_d;
    end
  end

  assign DATAread_out = strobe;
  assign _RESET_out   = (state_q != StArm);
  assign SLEAP_out    = (state_q == StRun);
  assign DATA_out     = data_q;
  assign ack_out      = ack_q;
  assign state_out    = state_q;
  assign words_out    = words_q;
  assign ovf_out      = ovf_q;
  assign udr_out      = udr_q;

endmodule

// File: tb/tb_acq_readout_seq.sv
// Directed bench for acq_readout_seq with a small event-FIFO model; the source
// writes 0xA000_0000 + n for the n-th word after each counter reset.
module tb_acq_readout_seq;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned TW = 24;

  logic          sys_clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [3:0]    cmd;
  logic [CW-1:0] acq_len;
  logic [TW-1:0] timeout;
  logic [CW-1:0] cnt;
  logic          full, empty;
  logic [DW-1:0] fifo_q;
  logic          rd_stb, cnt_rst_n, sleap, ack, ovf, udr;
  logic [DW-1:0] data_o;
  logic [2:0]    state;
  logic [CW-1:0] words;

  acq_readout_seq dut (
    .sys_clk      (sys_clk),
    ._RESET_in    (rst_n),
    .CMD_in       (cmd),
    .acq_len_in   (acq_len),
    .timeout_in   (timeout),
    .DATAcnt_in   (cnt),
    .full_in      (full),
    .empty_in     (empty),
    .DATA_in      (fifo_q),
    .DATAread_out (rd_stb),
    ._RESET_out   (cnt_rst_n),
    .SLEAP_out    (sleap),
    .DATA_out     (data_o),
    .ack_out      (ack),
    .state_out    (state),
    .words_out    (words),
    .ovf_out      (ovf),
    .udr_out      (udr)
  );

  always #5 sys_clk = ~sys_clk;

  // FIFO model: read data appears one cycle after the strobe.
  logic [DW-1:0] mem [256];
  logic [7:0]    wr_p, rd_p;
  int            src_cnt;
  int            budget = 0;
  logic          full_force = 1'b0;
  int            stb_total = 0;
  int            stb_empty = 0;

  assign cnt   = {8'd0, 8'(wr_p - rd_p)};
  assign empty = (wr_p == rd_p);
  assign full  = full_force;

  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_p    <= '0;
      rd_p    <= '0;
      src_cnt <= 0;
      fifo_q  <= '0;
    end else begin
      if (rd_stb) begin
        stb_total <= stb_total + 1;
        if (empty) stb_empty <= stb_empty + 1;
      end
      if (!cnt_rst_n) begin
        wr_p    <= '0;
        rd_p    <= '0;
        src_cnt <= 0;
      end else begin
        if (sleap && src_cnt < budget) begin
          mem[wr_p] <= 32'hA000_0000 + 32'(src_cnt);
          wr_p      <= wr_p + 8'd1;
          src_cnt   <= src_cnt + 1;
        end
        if (rd_stb && !empty) begin
          fifo_q <= mem[rd_p];
          rd_p   <= rd_p + 8'd1;
        end
      end
    end
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < lim; k++) begin
      @(negedge sys_clk);
      if (state == s) begin
        ok = 1'b1;
        break;
      end
    end
    check($sformatf("wait_state_%0d", s), 64'(ok), 64'd1);
  endtask

  // Toggle the request and watch strobe/ack arrival, in negedges after the toggle.
  task automatic do_read(output int stb_at, output int ack_at, output int nstb);
    cmd[2] = ~cmd[2];
    stb_at = 0;
    ack_at = 0;
    nstb   = 0;
    for (int k = 1; k <= 10 && ack_at == 0; k++) begin
      @(negedge sys_clk);
      if (rd_stb) begin
        nstb++;
        if (stb_at == 0) stb_at = k;
      end
      if (ack === cmd[2]) ack_at = k;
    end
  endtask

  int            arm_lo, run_cyc, sleap_run, arm_ent, stb_at, ack_at, nstb;
  logic [CW-1:0] last_cnt;
  logic [2:0]    prev;
  bit            done;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd     = '0;
    acq_len = '0;
    timeout = '0;

    // T1: asynchronous reset values, then quiet IDLE
    #2 rst_n = 1'b0;
    #1;
    check("rst_state", 64'(state), 64'd0);
    check("rst_sleap", 64'(sleap), 64'd0);
    check("rst_cntrst", 64'(cnt_rst_n), 64'd1);
    check("rst_strobe", 64'(rd_stb), 64'd0);
    check("rst_data", 64'(data_o), 64'd0);
    check("rst_flags", 64'({ack, ovf, udr}), 64'd0);
    check("rst_words", 64'(words), 64'd0);
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (100) @(negedge sys_clk);
    check("idle_strobes", 64'(stb_total), 64'd0);
    check("idle_state", 64'(state), 64'd0);
    check("idle_sleap", 64'(sleap), 64'd0);

    // T2: arm pulse, write window, stop on acquisition length
    acq_len = 16'd8;
    budget  = 8;
    cmd[0]  = 1'b1;
    arm_lo = 0; run_cyc = 0; sleap_run = 0; last_cnt = '0; done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge sys_clk);
      if (!cnt_rst_n) arm_lo++;
      if (state == 3'd2) begin
        run_cyc++;
        if (sleap) sleap_run++;
        last_cnt = cnt;
      end
      if (state == 3'd3) done = 1'b1;
      if (k == 1) cmd[0] = 1'b0;
    end
    check("t2_drain", 64'(done), 64'd1);
    check("t2_arm_low", 64'(arm_lo), 64'd4);
    // 8 writes land in the first 8 RUN cycles; the 9th sees count 8 and stops.
    check("t2_run_cyc", 64'(run_cyc), 64'd9);
    check("t2_sleap_run", 64'(sleap_run), 64'd9);
    check("t2_last_cnt", 64'(last_cnt), 64'd8);
    check("t2_sleap_drain", 64'(sleap), 64'd0);
    check("t2_fifo_cnt", 64'(cnt), 64'd8);

    // T3: drain 8 words, one strobe per toggle
    for (int i = 0; i < 8; i++) begin
      do_read(stb_at, ack_at, nstb);
      check($sformatf("t3_stb_at_%0d", i), 64'(stb_at), 64'd1);
      check($sformatf("t3_nstb_%0d", i), 64'(nstb), 64'd1);
      // ack lands on the edge closing the cycle after the strobe
      check($sformatf("t3_ack_at_%0d", i), 64'(ack_at), 64'd3);
      check($sformatf("t3_data_%0d", i), 64'(data_o), 64'hA000_0000 + 64'(i));
    end
    check("t3_words", 64'(words), 64'd8);
    check("t3_udr", 64'(udr), 64'd0);

    // T4: request while empty -> underrun, immediate ack, data held
    do_read(stb_at, ack_at, nstb);
    check("t4_nstb", 64'(nstb), 64'd0);
    check("t4_ack_at", 64'(ack_at), 64'd2);
    check("t4_udr", 64'(udr), 64'd1);
    check("t4_data", 64'(data_o), 64'hA000_0007);
    check("t4_words", 64'(words), 64'd8);
    check("t4_state", 64'(state), 64'd3);

    // T5: held start arms once; timeout ends RUN after 20 cycles
    timeout = 24'd20;
    acq_len = '0;
    budget  = 255;
    cmd[0]  = 1'b1;
    arm_ent = 0; run_cyc = 0; prev = state;
    for (int k = 0; k < 50; k++) begin
      @(negedge sys_clk);
      if (state == 3'd1 && prev != 3'd1) arm_ent++;
      if (state == 3'd2) run_cyc++;
      prev = state;
    end
    check("t5_arm_once", 64'(arm_ent), 64'd1);
    check("t5_run_cyc", 64'(run_cyc), 64'd20);
    check("t5_state", 64'(state), 64'd3);
    check("t5_words_clr", 64'(words), 64'd0);
    check("t5_udr_clr", 64'(udr), 64'd0);
    cmd[0]  = 1'b0;
    timeout = '0;
    @(negedge sys_clk);
    cmd[0] = 1'b1;
    wait_state(3'd2, 20);
    repeat (3) @(negedge sys_clk);
    check("t5_run_hold", 64'(state), 64'd2);
    check("t5_ovf_pre", 64'(ovf), 64'd0);
    full_force = 1'b1;
    @(negedge sys_clk);
    full_force = 1'b0;
    check("t5_full_drain", 64'(state), 64'd3);
    check("t5_ovf", 64'(ovf), 64'd1);
    check("t5_sleap_off", 64'(sleap), 64'd0);

    // T6: abort handling
    cmd = 4'b0000;
    @(negedge sys_clk);
    cmd = 4'b1000;
    @(negedge sys_clk);
    check("t6_abort_drain", 64'(state), 64'd0);
    cmd = 4'b0000;
    @(negedge sys_clk);
    cmd = 4'b1001;
    @(negedge sys_clk);
    check("t6_start_abort", 64'(state), 64'd0);
    @(negedge sys_clk);
    check("t6_start_abort_hold", 64'(state), 64'd0);
    cmd = 4'b0000;
    @(negedge sys_clk);
    acq_len = 16'd3;
    budget  = 3;
    cmd[0]  = 1'b1;
    wait_state(3'd3, 40);
    cmd[0] = 1'b0;
    check("t6_fifo_cnt", 64'(cnt), 64'd3);
    do_read(stb_at, ack_at, nstb);
    check("t6_first_data", 64'(data_o), 64'hA000_0000);
    check("t6_first_words", 64'(words), 64'd1);
    cmd[2] = ~cmd[2];
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge sys_clk);
      if (rd_stb) done = 1'b1;
    end
    check("t6_strobe_seen", 64'(done), 64'd1);
    @(negedge sys_clk);
    check("t6_in_read", 64'(state), 64'd4);
    cmd[3] = 1'b1;
    @(negedge sys_clk);
    check("t6_abort_idle", 64'(state), 64'd0);
    check("t6_abort_words", 64'(words), 64'd1);
    check("t6_abort_data", 64'(data_o), 64'hA000_0000);
    check("t6_abort_ack", 64'(ack), 64'(cmd[2]));
    check("t6_abort_outs", 64'({rd_stb, cnt_rst_n, sleap}), 64'b010);
    cmd = 4'b0000;
    @(negedge sys_clk);
    acq_len = '0;
    cmd[0]  = 1'b1;
    wait_state(3'd2, 20);
    check("t6_run_sleap", 64'(sleap), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_sleap", 64'(sleap), 64'd0);
    check("t6_async_state", 64'(state), 64'd0);
    check("t6_async_words", 64'(words), 64'd0);
    check("t6_async_data", 64'(data_o), 64'd0);
    check("t6_async_cntrst", 64'(cnt_rst_n), 64'd1);

    check("strobe_total", 64'(stb_total), 64'd10);
    check("strobe_on_empty", 64'(stb_empty), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
